// File: rtl/gcd_controller.sv
//------------------------------------------------------------------------------
// Module      : gcd_controller
// Description : Subtractive GCD engine. Samples two WIDTH-bit operands on an
//               accepted start, flags a zero operand, otherwise performs one
//               subtraction per cycle until the operands match.
//               Optional build macro GCD_ITER_COUNT_EN adds the iter_cnt output
//               reporting the number of subtractions performed.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gcd_controller #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             err
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [WIDTH-1:0] iter_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_gcd;
    logic             r_err;

    logic             w_accept;
    logic             w_zero_op;
    logic             w_equal;
    logic             w_x_lt_y;

    // Operand comparisons shared by the FSM and the datapath
    always_comb begin
        w_accept  = (r_state == IDLE) && start;
        w_zero_op = (r_x == '0) || (r_y == '0);
        w_equal   = (r_x == r_y);
        w_x_lt_y  = (r_x < r_y);
    end

    // State register; reset aborts any computation without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and Moore outputs; start only matters in IDLE
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = CHECK;
                end
            end
            CHECK: begin
                w_next_state = w_zero_op ? DONE : CMP;
            end
            CMP: begin
                if (w_equal) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand/result datapath: load on accept, one subtraction per CMP cycle.
    // The smaller operand is always the subtrahend, so no wrap can occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_gcd <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x   <= x_in;
                        r_y   <= y_in;
                        r_err <= 1'b0;
                    end
                end
                CHECK: begin
                    if (w_zero_op) begin
                        r_err <= 1'b1;
                        r_gcd <= '0;
                    end
                end
                CMP: begin
                    if (w_equal) begin
                        r_gcd <= r_x;
                    end else if (w_x_lt_y) begin
                        r_y <= r_y - r_x;
                    end else begin
                        r_x <= r_x - r_y;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign gcd_out = r_gcd;
    assign err     = r_err;

`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] r_iter_cnt;

    // Subtraction counter: cleared on accept, bumped on each non-final CMP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iter_cnt <= '0;
        end else if (w_accept) begin
            r_iter_cnt <= '0;
        end else if ((r_state == CMP) && !w_equal) begin
            r_iter_cnt <= r_iter_cnt + 1'b1;
        end
    end

    assign iter_cnt = r_iter_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_gcd_controller
// Description : Self-checking bench for gcd_controller. Table of directed
//               operand pairs with hand-computed results and latencies, plus
//               sequences for ignored restart and mid-run reset.
//               Honours GCD_ITER_COUNT_EN when the design is built with it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gcd_controller;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd_out;
    logic             err;
`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_cnt;
`endif

    int total = 0;
    int bad   = 0;

    gcd_controller #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x_in    (x_in),
        .y_in    (y_in),
        .busy    (busy),
        .done    (done),
        .gcd_out (gcd_out),
        .err     (err)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_cnt(iter_cnt)
`endif
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] exp_gcd;
        logic             exp_err;
        int               exp_edges;
        int               exp_iter;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Issue one start with the given operands and measure the run
    task automatic run_gcd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic [WIDTH-1:0] exp_gcd, input logic exp_err,
                           input int exp_edges, input int exp_iter);
        int n;
        @(negedge clk);
        x_in  = x;
        y_in  = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        chk("err_cleared_at_accept", int'(err), 0);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", int'(done), 1);
        chk("latency_edges", n, exp_edges);
        chk("gcd_out", int'(gcd_out), int'(exp_gcd));
        chk("err", int'(err), int'(exp_err));
`ifdef GCD_ITER_COUNT_EN
        chk("iter_cnt", int'(iter_cnt), exp_iter);
`else
        if (exp_iter < 0) $display("unexpected negative iteration count");
`endif
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(done), 0);
        chk("idle_after_done", int'(busy), 0);
        chk("gcd_holds", int'(gcd_out), int'(exp_gcd));
    endtask

    initial begin
        int n;
        bit saw_done;

        //          x      y      gcd    err   edges iter
        vecs[0] = '{4'd12, 4'd8,  4'd4,  1'b0, 4,    2};
        vecs[1] = '{4'd15, 4'd1,  4'd1,  1'b0, 16,   14};
        vecs[2] = '{4'd0,  4'd9,  4'd0,  1'b1, 1,    0};
        vecs[3] = '{4'd12, 4'd8,  4'd4,  1'b0, 4,    2};
        vecs[4] = '{4'd7,  4'd0,  4'd0,  1'b1, 1,    0};
        vecs[5] = '{4'd6,  4'd6,  4'd6,  1'b0, 2,    0};
        vecs[6] = '{4'd7,  4'd5,  4'd1,  1'b0, 6,    4};
        vecs[7] = '{4'd0,  4'd0,  4'd0,  1'b1, 1,    0};
        vecs[8] = '{4'd10, 4'd4,  4'd2,  1'b0, 5,    3};

        rst_n = 1'b0;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_gcd", int'(gcd_out), 0);
`ifdef GCD_ITER_COUNT_EN
        chk("rst_iter", int'(iter_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_gcd(vecs[i].x, vecs[i].y, vecs[i].exp_gcd, vecs[i].exp_err,
                    vecs[i].exp_edges, vecs[i].exp_iter);
        end

        // Restart during CMP of a 9,6 run must be ignored
        @(negedge clk);
        x_in  = 4'd9;
        y_in  = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        @(posedge clk);
        #1;
        n++;
        @(negedge clk);
        x_in  = 4'd3;
        y_in  = 4'd15;
        start = 1'b1;
        @(posedge clk);
        #1;
        n++;
        start = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("restart_done_seen", int'(done), 1);
        chk("restart_latency", n, 4);
        chk("restart_gcd", int'(gcd_out), 3);
        @(posedge clk);
        #1;
        chk("restart_idle", int'(busy), 0);

        // Reset at the 5th subtraction of a 15,1 run aborts without done
        @(negedge clk);
        x_in  = 4'd15;
        y_in  = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_gcd", int'(gcd_out), 0);
        chk("abort_err", int'(err), 0);
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", int'(saw_done), 0);
        chk("abort_stays_idle", int'(busy), 0);
        run_gcd(4'd10, 4'd4, 4'd2, 1'b0, 5, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a GCD computation.
REQ-005 The block SHALL have ports x_in and y_in, input, WIDTH bits each: the operands, sampled only on an accepted start.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-008 The block SHALL have port gcd_out, output, WIDTH bits: the result.
REQ-009 The block SHALL have port err, output, 1 bit: flags a zero operand.

Function
REQ-010 The FSM SHALL have exactly these states: IDLE, CHECK, CMP, DONE.
REQ-011 In IDLE with start=1, the block SHALL load X<=x_in and Y<=y_in, clear err, and move to CHECK on that edge (the "accept edge").
REQ-012 start SHALL be ignored in CHECK, CMP and DONE; operands are never re-sampled mid-computation.
REQ-013 In CHECK, if X==0 or Y==0 the block SHALL set err=1 and gcd_out=0 and go to DONE; otherwise it SHALL go to CMP.
REQ-014 In CMP, when X==Y the block SHALL load gcd_out<=X and go to DONE.
REQ-015 In CMP, when X<Y (unsigned) the block SHALL set Y<=Y-X and stay in CMP.
REQ-016 In CMP, when X>Y the block SHALL set X<=X-Y and stay in CMP.
REQ-017 CMP SHALL perform exactly one subtraction per cycle; results SHALL be WIDTH bits with no wrap possible, since the subtrahend is always the smaller operand.
REQ-018 DONE SHALL drive done=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-019 Latency: for S subtractions, done SHALL be high in the cycle following the (S+2)th rising edge after the accept edge; for a zero operand, in the cycle following the 1st edge after the accept edge.
REQ-020 gcd_out and err SHALL hold their values from DONE until the next DONE or reset; err is additionally cleared at the accept edge.
REQ-021 Worst case (WIDTH=4, operands 15 and 1) SHALL take S=14 subtractions with no overflow.

Reset
REQ-022 rst_n=0 SHALL immediately force the state to IDLE and set busy=0, done=0, err=0, gcd_out=0, X=0 and Y=0, regardless of clk.
REQ-023 A reset asserted during CHECK or CMP SHALL abort the computation with no done pulse.
REQ-024 After rst_n deasserts, the first start SHALL be accepted normally.

Configuration
REQ-025 With macro GCD_ITER_COUNT_EN defined, the block SHALL add output iter_cnt (WIDTH bits), which is cleared at the accept edge, increments once per CMP subtraction, holds after DONE, and is reset to 0.
REQ-026 Without GCD_ITER_COUNT_EN, the iter_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Basic case: x_in=12, y_in=8, start pulsed -> done high 4 edges after the accept edge, gcd_out=4, err=0, iter_cnt=2.
REQ-028 Worst case: x_in=15, y_in=1 -> gcd_out=1, iter_cnt=14, done high 16 edges after the accept edge.
REQ-029 Zero operands: x_in=0, y_in=9 -> done high 1 edge after the accept edge, err=1, gcd_out=0; the same result SHALL be produced for x_in=7, y_in=0.
REQ-030 Equal operands and ignored restart: x_in=6, y_in=6 -> gcd_out=6 with S=0; a start pulsed with x_in=3 during CMP of a 9,6 run -> ignored, result 3 from 9,6.
REQ-031 Reset mid-operation: run 15,1, drop rst_n at iteration 5 -> busy=0, no done; then run 10,4 -> gcd_out=2.
